// File: rtl/de10_bus_pkg.sv
// de10_bus_pkg: shared state encoding, default DE10 slave tags and error data for the bus fabric.
package de10_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
    localparam logic [9:0] TAG_SRAM = 10'h0;
    localparam logic [9:0] TAG_PERIPH = 10'h1;
    localparam logic [9:0] TAG_SDRAM = 10'h2;
    localparam logic [31:0] ERR_DATA = 32'h0;
endpackage

// File: rtl/de10_bus_addr_decode.sv
// de10_bus_addr_decode: tag compare to one-hot slave select; duplicate tags resolve to the lowest index.
module de10_bus_addr_decode #(
    parameter int TAG_W = 10,
    parameter int NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*TAG_W-1:0] SLAVE_TAGS = '0
) (
    input  logic [TAG_W-1:0]      tag,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && SLAVE_TAGS[i*TAG_W +: TAG_W] == tag) begin
                sel[i] = 1'b1;
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/de10_bus_fabric.sv
// de10_bus_fabric: single-master registered address decoder with ready wait, decode-error and timeout responses.
module de10_bus_fabric
    import de10_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W = 10,
    parameter int NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*TAG_W-1:0] SLAVE_TAGS = {TAG_SDRAM, TAG_PERIPH, TAG_SRAM},
    parameter int TIMEOUT = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic [NUM_SLAVES-1:0]        s_en,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    output logic                         err,
    output logic                         busy
);
    localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [NUM_SLAVES-1:0] sel;
    logic hit;
    logic [DATA_W-1:0] sel_data;
    logic sel_ready;
    logic expired;
    de10_bus_addr_decode #(
        .TAG_W(TAG_W),
        .NUM_SLAVES(NUM_SLAVES),
        .SLAVE_TAGS(SLAVE_TAGS)
    ) u_dec (
        .tag(addr[ADDR_W-1 -: TAG_W]),
        .sel(sel),
        .hit(hit)
    );
    // s_en doubles as the remembered selection while waiting
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel_data = sel_data | (s_en[i] ? s_data[i*DATA_W +: DATA_W] : '0);
    end
    assign sel_ready = |(s_ready & s_en);
    assign expired = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            s_en <= '0;
            s_addr <= '0;
            rdata <= '0;
            rvalid <= 1'b0;
            err <= 1'b0;
            cnt <= '0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (hit) begin
                        s_en <= sel;
                        s_addr <= addr;
                        cnt <= '0;
                        state <= WAIT;
                    end else begin
                        state <= ERR;
                    end
                end
                WAIT: if (sel_ready || expired) begin
                    rdata <= sel_ready ? sel_data : DATA_W'(ERR_DATA);
                    rvalid <= 1'b1;
                    err <= !sel_ready;
                    s_en <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                ERR: begin
                    rdata <= DATA_W'(ERR_DATA);
                    rvalid <= 1'b1;
                    err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_de10_bus_fabric.sv
// tb_de10_bus_fabric: randomized transaction-level checks of the bus fabric against a behavioural model.
module tb_de10_bus_fabric;
    localparam int TO = 8;
    localparam logic [9:0] TAGS [3] = '{10'h0, 10'h1, 10'h2};
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0;
    logic [31:0] addr = '0;
    logic [95:0] s_data = '0;
    logic [2:0] s_ready = '0;
    logic [2:0] s_en;
    logic [31:0] s_addr, rdata;
    logic rvalid, err, busy;
    logic [31:0] sd [3];
    int tests = 0;
    int fails = 0;

    de10_bus_fabric #(.TIMEOUT(TO), .SLAVE_TAGS({10'h2, 10'h1, 10'h0})) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .s_data(s_data), .s_ready(s_ready),
        .s_en(s_en), .s_addr(s_addr), .rdata(rdata), .rvalid(rvalid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_sel(input logic [31:0] a);
        for (int i = 0; i < 3; i++) if (TAGS[i] == a[31:22]) return i;
        return -1;
    endfunction

    function automatic bool_ok(input int sel, input int ready_at);
        return sel >= 0 && ready_at != 0 && ready_at <= TO;
    endfunction

    function automatic int ref_lat(input int sel, input int ready_at);
        if (sel < 0) return 2;
        return bool_ok(sel, ready_at) ? ready_at + 1 : TO + 1;
    endfunction

    // Drives one request; ready_at is the WAIT cycle (1-based) the target's ready rises, 0 = never.
    // Returns at the rvalid cycle with req still high.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input int ready_at, input bit swap,
                       output int lat, output logic [2:0] en_or, output int busy_n);
        int tgt;
        logic [2:0] r;
        tgt = ref_sel(a);
        for (int i = 0; i < 3; i++) sd[i] = $urandom;
        if (tgt >= 0) sd[tgt] = d;
        s_data = {sd[2], sd[1], sd[0]};
        req = 1'b1;
        addr = a;
        lat = -1;
        en_or = '0;
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            r = 3'($urandom);
            if (tgt >= 0) r[tgt[1:0]] = (ready_at != 0 && c >= ready_at);
            s_ready = r;
            tick();
            en_or |= s_en;
            if (busy) busy_n++;
            if (rvalid) begin
                lat = c + 1;
                break;
            end
            if (swap && c == 1) addr = $urandom;
        end
        s_ready = '0;
    endtask

    task automatic idle;
        req = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if ({s_en, s_addr, rdata, rvalid, err, busy} !== '0) begin
            fails++;
            $display("FAIL reset: outputs %0h want 0", {s_en, s_addr, rdata, rvalid, err, busy});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hit_immediate;
        int lat, bn;
        logic [2:0] en;
        txn(32'h0000_0040, 32'hDEAD_BEEF, 1, 1'b0, lat, en, bn);
        tests++;
        if ({lat, rdata, err, en} !== {32'd2, 32'hDEAD_BEEF, 1'b0, 3'b001}) begin
            fails++;
            $display("FAIL hit_immediate: lat=%0d rdata=%h err=%b en=%b want 2 deadbeef 0 001", lat, rdata, err, en);
        end
        idle();
        tests++;
        if ({rvalid, rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL rvalid_pulse: rvalid=%b rdata=%h want 0 deadbeef", rvalid, rdata);
        end
    endtask

    task automatic test_waited_hit;
        int lat, bn;
        logic [2:0] en;
        txn(32'h0080_0000, 32'h1234_5678, 6, 1'b0, lat, en, bn);
        tests++;
        if ({lat, bn, rdata, err, en, s_addr} !== {32'd7, 32'd6, 32'h1234_5678, 1'b0, 3'b100, 32'h0080_0000}) begin
            fails++;
            $display("FAIL waited_hit: lat=%0d busy=%0d rdata=%h err=%b en=%b s_addr=%h", lat, bn, rdata, err, en, s_addr);
        end
        idle();
    endtask

    task automatic test_miss;
        int lat, bn;
        logic [2:0] en;
        txn(32'hFFC0_0000, 32'h0, 0, 1'b0, lat, en, bn);
        tests++;
        if ({lat, bn, rdata, err, en} !== {32'd2, 32'd1, 32'h0, 1'b1, 3'b000}) begin
            fails++;
            $display("FAIL miss: lat=%0d busy=%0d rdata=%h err=%b en=%b want 2 1 0 1 000", lat, bn, rdata, err, en);
        end
        idle();
    endtask

    task automatic test_timeout;
        int lat, bn;
        logic [2:0] en;
        txn(32'h0040_0000, 32'hA5A5_0001, 0, 1'b0, lat, en, bn);
        tests++;
        if ({lat, rdata, err, en, s_en} !== {32'd9, 32'h0, 1'b1, 3'b010, 3'b000}) begin
            fails++;
            $display("FAIL timeout: lat=%0d rdata=%h err=%b en=%b s_en=%b want 9 0 1 010 000", lat, rdata, err, en, s_en);
        end
        idle();
        txn(32'h0040_0000, 32'hA5A5_0002, TO, 1'b0, lat, en, bn);
        tests++;
        if ({lat, rdata, err} !== {32'd9, 32'hA5A5_0002, 1'b0}) begin
            fails++;
            $display("FAIL ready_at_timeout: lat=%0d rdata=%h err=%b want 9 a5a50002 0", lat, rdata, err);
        end
        idle();
    endtask

    task automatic test_reset_mid;
        int lat, bn, rv;
        logic [2:0] en;
        req = 1'b1;
        addr = 32'h0040_0010;
        s_ready = '0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        req = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if ({s_en, s_addr, rdata, rvalid, err, busy} !== '0) begin
            fails++;
            $display("FAIL reset_mid: outputs %0h want 0", {s_en, s_addr, rdata, rvalid, err, busy});
        end
        rv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rvalid) rv++;
        end
        tests++;
        if (rv !== 0) begin
            fails++;
            $display("FAIL reset_no_resp: rvalid count %0d want 0", rv);
        end
        txn(32'h0040_0020, 32'h0BAD_CAFE, 2, 1'b0, lat, en, bn);
        tests++;
        if ({lat, rdata, err, en} !== {32'd3, 32'h0BAD_CAFE, 1'b0, 3'b010}) begin
            fails++;
            $display("FAIL after_reset: lat=%0d rdata=%h err=%b en=%b want 3 0badcafe 0 010", lat, rdata, err, en);
        end
        idle();
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        logic [2:0] en;
        txn(32'h0000_1000, 32'h1111_2222, 4, 1'b1, lat, en, bn);
        tests++;
        if ({lat, rdata, err, s_addr} !== {32'd5, 32'h1111_2222, 1'b0, 32'h0000_1000}) begin
            fails++;
            $display("FAIL busy_ignore: lat=%0d rdata=%h err=%b s_addr=%h want 5 11112222 0 00001000", lat, rdata, err, s_addr);
        end
        txn(32'h0080_0044, 32'h3333_4444, 1, 1'b0, lat, en, bn);
        tests++;
        if ({lat, rdata, err, en, s_addr} !== {32'd2, 32'h3333_4444, 1'b0, 3'b100, 32'h0080_0044}) begin
            fails++;
            $display("FAIL back_to_back: lat=%0d rdata=%h err=%b en=%b s_addr=%h", lat, rdata, err, en, s_addr);
        end
        idle();
    endtask

    task automatic test_random;
        int lat, bn, sel, ra, el;
        logic [2:0] en;
        logic [31:0] a, d, erd;
        logic [9:0] tag;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(4))
                0: tag = 10'h0;
                1: tag = 10'h1;
                2: tag = 10'h2;
                3: tag = 10'h3FF;
                default: tag = 10'($urandom);
            endcase
            a = {tag, 22'($urandom)};
            d = $urandom;
            ra = $urandom_range(10);
            sel = ref_sel(a);
            el = ref_lat(sel, ra);
            erd = bool_ok(sel, ra) ? d : 32'h0;
            txn(a, d, ra, n[0], lat, en, bn);
            tests++;
            if ({lat, bn, rdata, err, en} !== {el, el - 1, erd, !bool_ok(sel, ra), sel >= 0 ? 3'(1 << sel) : 3'b000}) begin
                fails++;
                $display("FAIL random[%0d] a=%h ra=%0d: lat=%0d busy=%0d rdata=%h err=%b en=%b want %0d %0d %h %b",
                         n, a, ra, lat, bn, rdata, err, en, el, el - 1, erd, !bool_ok(sel, ra));
            end
            if (sel >= 0) begin
                tests++;
                if (s_addr !== a) begin
                    fails++;
                    $display("FAIL random_saddr[%0d]: s_addr=%h want %h", n, s_addr, a);
                end
            end
            if (n % 3 != 0) idle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_hit_immediate();
        test_waited_hit();
        test_miss();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
